// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with a 2-flop row synchroniser,
// tick-paced debounce and a one-clock valid strobe. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_TICKS = 200
) (
    input  logic       clock,
    input  logic       clearA,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] value,
    output logic       valid,
    output logic       held,
    output logic [1:0] dbg_state_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       row_meta_q;
    logic [3:0]       rs_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;
    logic [3:0]       col_q;
    logic [3:0]       col_next;
    logic [3:0]       cand_row_q;
    logic [1:0]       cand_col_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_next;
    logic [DEB_W-1:0] rel_cnt_q;
    logic [DEB_W-1:0] rel_next;
    logic [3:0]       value_q;
    logic             valid_q;
    logic             held_q;
    logic             rs_idle;
    logic             rs_match;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_next;
    assign rep_next = rep_cnt_q + REP_W'(1);
`endif

    function automatic logic [1:0] col_index(input logic [3:0] c);
        logic [1:0] idx;
        case (c)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    always_ff @(posedge clock or negedge clearA) begin
        if (!clearA) begin
            row_meta_q <= 4'hF;
            rs_q       <= 4'hF;
        end else begin
            row_meta_q <= row;
            rs_q       <= row_meta_q;
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clock or negedge clearA) begin
        if (!clearA) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign rs_idle  = (rs_q == 4'hF);
    assign rs_match = (rs_q == cand_row_q);
    assign deb_next = deb_cnt_q + DEB_W'(1);
    assign rel_next = rel_cnt_q + DEB_W'(1);
    assign col_next = {col_q[2:0], col_q[3]};

    // valid is a bare strobe with no ready: the consumer must capture value on the pulse.
    always_ff @(posedge clock or negedge clearA) begin
        if (!clearA) begin
            state_q    <= ST_SCAN;
            col_q      <= 4'b1110;
            cand_row_q <= 4'hF;
            cand_col_q <= 2'd0;
            deb_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            value_q    <= 4'h0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (!rs_idle) begin
                            cand_row_q <= rs_q;
                            cand_col_q <= col_index(col_q);
                            deb_cnt_q  <= '0;
                            state_q    <= ST_DEBOUNCE;
                        end else begin
                            col_q <= col_next;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (rs_match) begin
                            if (deb_next == DEB_LAST) begin
                                value_q   <= key_code(row_index(cand_row_q), cand_col_q);
                                valid_q   <= 1'b1;
                                held_q    <= 1'b1;
                                deb_cnt_q <= '0;
                                rel_cnt_q <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt_q <= '0;
`endif
                                state_q   <= ST_PRESSED;
                            end else begin
                                deb_cnt_q <= deb_next;
                            end
                        end else begin
                            col_q   <= col_next;
                            state_q <= ST_SCAN;
                        end
                    end
                    ST_PRESSED: begin
                        // Any low row, including a second key, counts as still pressed.
                        if (rs_idle) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_q <= '0;
`endif
                            if (rel_next == DEB_LAST) begin
                                rel_cnt_q <= '0;
                                held_q    <= 1'b0;
                                col_q     <= col_next;
                                state_q   <= ST_SCAN;
                            end else begin
                                rel_cnt_q <= rel_next;
                            end
                        end else begin
                            rel_cnt_q <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rep_next == REP_LAST) begin
                                rep_cnt_q <= '0;
                                valid_q   <= 1'b1;
                            end else begin
                                rep_cnt_q <= rep_next;
                            end
`endif
                        end
                    end
                    default: begin
                        state_q <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign col         = col_q;
    assign value       = value_q;
    assign valid       = valid_q;
    assign held        = held_q;
    assign dbg_state_o = state_q;

    // A strobe only ever accompanies an accepted, still-held key; the drive stays one-cold.
    a_col_one_cold: assert property (@(posedge clock) disable iff (!clearA) $onehot(~col_q));
    a_valid_held:   assert property (@(posedge clock) disable iff (!clearA) valid_q |-> held_q);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 key matrix into keypad_scanner and scores
// every valid strobe against codes predicted from the key map and row-priority rule.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SD      = 4;
    localparam int DB      = 3;
    localparam int RT      = 5;
    localparam int LAT_MAX = 4*SD + DB*SD + 3;
    localparam int MIN_GAP = (2*DB + 1)*SD;

    // Index is row*4 + column.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic       clock = 1'b0;
    logic       clearA = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] value;
    logic       valid;
    logic       held;
    logic [1:0] dbg_state;

    bit         pressed [16];
    bit         force_en = 1'b1;
    logic [3:0] force_val = 4'b1011;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         press_cyc = -1;
    int         last_valid_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [3:0] last_val = 4'h0;
    logic [3:0] mon_exp;
    logic [3:0] exp_q [$];

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE     (DB),
        .REPEAT_TICKS (RT)
    ) dut (
        .clock       (clock),
        .clearA      (clearA),
        .row         (row),
        .col         (col),
        .value       (value),
        .valid       (valid),
        .held        (held),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Passive key matrix: a pressed key shorts its row to the driven (low) column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
            end
        end
        if (force_en) row = force_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (clearA && valid) begin
            valid_cnt++;
            check("valid_one_clk", 32'(prev_valid), 32'(0));
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("strobe_value", 32'(value), 32'(mon_exp));
                last_val = mon_exp;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                check("repeat_value", 32'(value), 32'(last_val));
`else
                check("unexpected_valid", 32'(valid), 32'(0));
`endif
            end
            if (press_cyc >= 0) begin
                check("latency_bound", 32'(cyc - press_cyc <= LAT_MAX), 32'(1));
                press_cyc = -1;
            end
`ifndef KEYPAD_AUTOREPEAT_EN
            if (last_valid_cyc >= 0)
                check("valid_spacing", 32'(cyc - last_valid_cyc >= MIN_GAP), 32'(1));
`endif
            last_valid_cyc = cyc;
        end
        prev_valid = valid;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_key(input int k, input bit expect_strobe);
        @(negedge clock);
        if (expect_strobe) exp_q.push_back(KEY_MAP[k]);
        pressed[k] = 1'b1;
        if (expect_strobe) press_cyc = cyc;
    endtask

    task automatic release_all();
        @(negedge clock);
        for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (held !== lvl && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(held), 32'(lvl));
    endtask

    task automatic pulse_reset_check();
        @(negedge clock);
        clearA = 1'b0;
        #1;
        check("rst_value", 32'(value), 32'(0));
        check("rst_held", 32'(held), 32'(0));
        check("rst_col", 32'(col), 32'(4'b1110));
        wait_clks(3);
        check("rst_valid", 32'(valid), 32'(0));
        clearA = 1'b1;
        last_valid_cyc = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int k;
        int rst_iter;

        for (int i = 0; i < 16; i++) pressed[i] = 1'b0;

        // Reset held with a stray row pattern on the lines.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("reset_col", 32'(col), 32'(4'b1110));
            check("reset_value", 32'(value), 32'(0));
            check("reset_valid", 32'(valid), 32'(0));
            check("reset_held", 32'(held), 32'(0));
        end
        force_en = 1'b0;
        @(negedge clock);
        clearA = 1'b1;
        wait_clks(2*SD);

        // Clean press of key 5, held 20 ticks.
        c0 = valid_cnt;
        press_key(5, 1'b1);
        wait_clks(20*SD);
        check("clean_value", 32'(value), 32'(4'h5));
        check("clean_held", 32'(held), 32'(1));
`ifndef KEYPAD_AUTOREPEAT_EN
        check("clean_one_valid", 32'(valid_cnt - c0), 32'(1));
`endif
        release_all();
        wait_held(1'b0, (DB + 2)*SD, "clean_release");
        check("col_after_release", 32'(col), 32'(4'b1011));
        check("value_kept", 32'(value), 32'(4'h5));
        wait_clks(3*SD);

        // Bouncing key A, then held.
        c0 = valid_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pressed[3] = 1'b1;
            wait_clks(SD);
            pressed[3] = 1'b0;
            wait_clks(SD);
        end
        check("bounce_no_valid", 32'(valid_cnt - c0), 32'(0));
        press_key(3, 1'b1);
        wait_held(1'b1, LAT_MAX + 2, "bounce_accept");
        wait_clks(2*SD);
        check("bounce_one_valid", 32'(valid_cnt - c0), 32'(1));
        check("bounce_value", 32'(value), 32'(4'hA));
        release_all();
        wait_held(1'b0, (DB + 2)*SD, "bounce_release");
        wait_clks(3*SD);

        // Keys 3 and 9 together in column 2: row 0 wins. Then F joins.
        c0 = valid_cnt;
        @(negedge clock);
        exp_q.push_back(KEY_MAP[2]);
        pressed[2] = 1'b1;
        pressed[10] = 1'b1;
        press_cyc = cyc;
        wait_held(1'b1, LAT_MAX + 2, "two_key_accept");
        check("two_key_value", 32'(value), 32'(4'h3));
        press_key(14, 1'b0);
        wait_clks(10*SD);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("two_key_no_new", 32'(valid_cnt - c0), 32'(1));
`endif
        check("two_key_still", 32'(value), 32'(4'h3));
        release_all();
        wait_held(1'b0, (DB + 2)*SD, "two_key_release");
        wait_clks(3*SD);

        // B, 7, # as the control unit would see them.
        c0 = valid_cnt;
        foreach (KEY_MAP[i]) begin
            if (i == 7 || i == 8 || i == 14) begin
                press_key(i, 1'b1);
                wait_held(1'b1, LAT_MAX + 2, "seq_accept");
                wait_clks(2*SD);
                release_all();
                wait_held(1'b0, (DB + 2)*SD, "seq_release");
                wait_clks(2*SD);
            end
        end
        check("seq_count", 32'(valid_cnt - c0), 32'(3));
        check("seq_last", 32'(value), 32'(4'hF));

        // Random keys; one iteration gets a reset while the key is down.
        rst_iter = $urandom_range(0, 9);
        for (int it = 0; it < 10; it++) begin
            k = $urandom_range(0, 15);
            press_key(k, 1'b1);
            wait_held(1'b1, LAT_MAX + 2, "rand_accept");
            check("rand_value", 32'(value), 32'(KEY_MAP[k]));
            wait_clks($urandom_range(0, 8)*SD + $urandom_range(0, 3));
            if (it == rst_iter) begin
                pulse_reset_check();
                exp_q.push_back(KEY_MAP[k]);
                press_cyc = cyc;
                wait_held(1'b1, LAT_MAX + 2, "rst_reaccept");
                check("rst_reaccept_value", 32'(value), 32'(KEY_MAP[k]));
            end
            release_all();
            wait_held(1'b0, (DB + 2)*SD, "rand_release");
            wait_clks($urandom_range(1, 4)*SD);
        end

`ifdef KEYPAD_AUTOREPEAT_EN
        // Key 9 held 20 ticks past acceptance: one strobe plus four repeats.
        c0 = valid_cnt;
        press_key(10, 1'b1);
        wait_held(1'b1, LAT_MAX + 2, "rep_accept");
        wait_clks(20*SD + 2);
        check("rep_count", 32'(valid_cnt - c0), 32'(5));
        check("rep_value", 32'(value), 32'(4'h9));
        @(negedge clock);
        clearA = 1'b0;
        #1;
        check("rep_rst_value", 32'(value), 32'(0));
        release_all();
        wait_clks(2);
        clearA = 1'b1;
        last_valid_cyc = -1;
        wait_clks(2*SD);
        check("rep_after_rst_held", 32'(held), 32'(0));
`endif

        wait_clks(4*SD);
        check("exp_q_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines, and emits a 4-bit key code with a one-clock `valid` strobe. It sits directly upstream of the calculator control unit: its `value` feeds the control unit's 4-bit key input, where A (1010) selects add, B (1011) selects subtract and F (1111) acts as enter. It runs on the same clock and async clear as the rest of the datapath.

## Interface
- `SCAN_DIV`, 100000: clocks per column slot; the scan tick fires once per slot.
- `DEBOUNCE`, 4: consecutive identical tick samples required to accept a press or a release; minimum 1.
- `REPEAT_TICKS`, 200: ticks between auto-repeat strobes; used only under `KEYPAD_AUTOREPEAT_EN`.
- `clock` input 1: system clock, rising edge.
- `clearA` input 1: reset, asynchronous, active-low.
- `row` input 4: keypad row lines, active-low, externally pulled up; asynchronous to `clock`.
- `col` output 4: column drive, active-low, one-cold.
- `value` output 4: last accepted key code; held until the next accepted press.
- `valid` output 1: one-clock pulse when `value` is updated or repeated.
- `held` output 1: high while an accepted key remains pressed.

## Operation
- `row` passes through a 2-flop synchroniser. All decisions use the synchronised value `rs`.
- Tick counter counts 0..SCAN_DIV-1. `tick` is high in the cycle the count equals SCAN_DIV-1, then the count wraps to 0. `rs` is sampled only on `tick`, so columns get a full slot to settle.
- Column sequence: 1110 → 1101 → 1011 → 0111 → 1110. It advances only on `tick` in SCAN.
- Key map, row r / column c → code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- Multiple rows low at once: the lowest-index low row wins.
- FSM states:
  - SCAN: on `tick`, if `rs` != 1111, latch `rs` and the current column into cand, clear the debounce counter, and go to DEBOUNCE with `col` frozen. Otherwise advance `col`.
  - DEBOUNCE: on `tick`, if `rs` == cand, increment the counter. When the counter reaches DEBOUNCE: load `value` with the decoded code, pulse `valid`, go to PRESSED. If `rs` != cand: go to SCAN, advance `col`, no output change.
  - PRESSED: `held`=1, `col` frozen. On `tick`, if `rs` == 1111, increment the release counter, else clear it. When the counter reaches DEBOUNCE, go to SCAN and advance `col`.
- A second key pressed in another column while in PRESSED is ignored. The original key's row staying low keeps the block in PRESSED.
- Reset values: `col`=1110, `value`=0000, `valid`=0, `held`=0, state=SCAN, all counters 0, synchroniser flops 1111.
- Reset deasserted mid-press: the block restarts in SCAN and must re-debounce the press. No spurious `valid` is produced.

## Timing
- `valid` asserts the cycle after the DEBOUNCE-th qualifying `tick` following the detection tick, and stays high exactly one clock.
- `value` changes in the same cycle `valid` rises.
- Press-to-`valid` latency is at most 4·SCAN_DIV + DEBOUNCE·SCAN_DIV + 3 clocks.
- `held` rises with `valid` and falls the cycle after the DEBOUNCE-th release tick.
- Minimum spacing between `valid` pulses without repeat: (2·DEBOUNCE+1)·SCAN_DIV clocks.
- Downstream consumers may sample `value` at any rate; it is stable between strobes.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined: in PRESSED, a repeat counter counts ticks while the key is held. Every REPEAT_TICKS ticks it re-pulses `valid` with `value` unchanged. The counter clears on entry to PRESSED and on every release-counter increment.
- `KEYPAD_AUTOREPEAT_EN` undefined: exactly one `valid` per accepted press. The repeat counter and REPEAT_TICKS logic are absent.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3.
- Reset: hold `clearA`=0 with `row`=1011 → `col`=1110, `value`=0000, `valid`=0, `held`=0 throughout.
- Clean press: drive row1 low only while `col`=1101 (key 5) for 20 ticks → one `valid` pulse, `value`=0101, `held`=1. Release for 3 ticks → `held`=0 and scanning resumes.
- Bounce: key A (r0, c3) toggled on 1 tick / off 1 tick, 4 times, then held → no `valid` during the bounce. Exactly one `valid` afterwards, with `value`=1010.
- Two keys: r0 and r2 both low in column 2 → `value`=0011 (key 3). Pressing F while 3 is held → no new `valid`.
- Sequence feeding the control unit: B, then 7, then # (each pressed and released) → three strobes with `value` 1011, 0111, 1111 in that order.
- Under `KEYPAD_AUTOREPEAT_EN` with REPEAT_TICKS=5: hold key 9 for 20 ticks after acceptance → 1 + 4 `valid` pulses, `value`=1001. Assert `clearA` low mid-hold → `value`=0000 immediately.
